// File: rtl/periph_bus_arbiter_if.sv
// Bundle of the two master request ports and the shared peripheral bus.
// The slave modport is the arbiter's view; the master modport is the requester/peripheral side.
interface periph_bus_arbiter_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;

    logic [AW-1:0] sys_w_addr;
    logic [AW-1:0] sys_r_addr;
    logic [DW-1:0] sys_w_line;
    logic [DW-1:0] sys_r_line;
    logic          sys_w;
    logic          sys_r;
    logic          busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  sys_r_line,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output sys_w_addr, sys_r_addr, sys_w_line, sys_w, sys_r, busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output sys_r_line,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  sys_w_addr, sys_r_addr, sys_w_line, sys_w, sys_r, busy
    );
endinterface

// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter onto a single peripheral read/write strobe bus.
// One transaction at a time; every output is a flop loaded from its next-state value.
module periph_bus_arbiter #(
    parameter int unsigned READ_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    periph_bus_arbiter_if.slave  bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WRITE   = 3'd1;
    localparam logic [2:0] READ    = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] RESP    = 3'd4;

    logic [2:0]    state,    state_nxt;
    logic [CW-1:0] cnt,      cnt_nxt;
    logic          last_gnt, last_gnt_nxt;
    logic          gnt,      gnt_nxt;
    logic [AW-1:0] w_addr,   w_addr_nxt;
    logic [AW-1:0] r_addr,   r_addr_nxt;
    logic [DW-1:0] w_line,   w_line_nxt;
    logic          sys_w,    sys_w_nxt;
    logic          sys_r,    sys_r_nxt;
    logic          ack0,     ack0_nxt;
    logic          ack1,     ack1_nxt;
    logic [DW-1:0] rdata0,   rdata0_nxt;
    logic [DW-1:0] rdata1,   rdata1_nxt;
    logic          busy,     busy_nxt;
    logic          pick;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            last_gnt <= 1'b1;
            gnt      <= 1'b0;
            w_addr   <= '0;
            r_addr   <= '0;
            w_line   <= '0;
            sys_w    <= 1'b0;
            sys_r    <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            last_gnt <= last_gnt_nxt;
            gnt      <= gnt_nxt;
            w_addr   <= w_addr_nxt;
            r_addr   <= r_addr_nxt;
            w_line   <= w_line_nxt;
            sys_w    <= sys_w_nxt;
            sys_r    <= sys_r_nxt;
            ack0     <= ack0_nxt;
            ack1     <= ack1_nxt;
            rdata0   <= rdata0_nxt;
            rdata1   <= rdata1_nxt;
            busy     <= busy_nxt;
        end
    end

    // Next-state and next-output logic; strobes and acks are single-cycle by default
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        last_gnt_nxt = last_gnt;
        gnt_nxt      = gnt;
        w_addr_nxt   = w_addr;
        r_addr_nxt   = r_addr;
        w_line_nxt   = w_line;
        rdata0_nxt   = rdata0;
        rdata1_nxt   = rdata1;
        sys_w_nxt    = 1'b0;
        sys_r_nxt    = 1'b0;
        ack0_nxt     = 1'b0;
        ack1_nxt     = 1'b0;

        // On a tie the master that did not win last time goes next
        if (bus.m0_req && bus.m1_req) pick = ~last_gnt;
        else                          pick = bus.m1_req;

        case (state)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    gnt_nxt      = pick;
                    last_gnt_nxt = pick;
                    if (pick ? bus.m1_we : bus.m0_we) begin
                        state_nxt  = WRITE;
                        sys_w_nxt  = 1'b1;
                        w_addr_nxt = pick ? bus.m1_addr  : bus.m0_addr;
                        w_line_nxt = pick ? bus.m1_wdata : bus.m0_wdata;
                    end else begin
                        state_nxt  = READ;
                        sys_r_nxt  = 1'b1;
                        r_addr_nxt = pick ? bus.m1_addr : bus.m0_addr;
                        cnt_nxt    = CW'(READ_LAT - 1);
                    end
                end
            end
            WRITE: begin
                state_nxt = RESP;
                ack0_nxt  = ~gnt;
                ack1_nxt  = gnt;
            end
            READ: begin
                if (cnt == '0) begin
                    state_nxt = CAPTURE;
                end else begin
                    cnt_nxt   = cnt - CW'(1);
                    sys_r_nxt = 1'b1;
                end
            end
            CAPTURE: begin
                if (gnt) rdata1_nxt = bus.sys_r_line;
                else     rdata0_nxt = bus.sys_r_line;
                state_nxt = RESP;
                ack0_nxt  = ~gnt;
                ack1_nxt  = gnt;
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    assign bus.m0_ack     = ack0;
    assign bus.m1_ack     = ack1;
    assign bus.m0_rdata   = rdata0;
    assign bus.m1_rdata   = rdata1;
    assign bus.sys_w_addr = w_addr;
    assign bus.sys_r_addr = r_addr;
    assign bus.sys_w_line = w_line;
    assign bus.sys_w      = sys_w;
    assign bus.sys_r      = sys_r;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: READ_LAT=1 and READ_LAT=3 instances, one active at a time,
// checked cycle by cycle against a transaction-level timing model.
module tb_periph_bus_arbiter;
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    periph_bus_arbiter_if if_a();
    periph_bus_arbiter_if if_b();

    periph_bus_arbiter #(.READ_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    periph_bus_arbiter #(.READ_LAT(3)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    int          sel;
    bit          tb_req [2];
    bit          tb_we  [2];
    logic [31:0] tb_addr[2];
    logic [31:0] tb_wd  [2];

    assign if_a.m0_req   = (sel == 0) && tb_req[0];
    assign if_a.m1_req   = (sel == 0) && tb_req[1];
    assign if_b.m0_req   = (sel == 1) && tb_req[0];
    assign if_b.m1_req   = (sel == 1) && tb_req[1];
    assign if_a.m0_we    = tb_we[0];
    assign if_a.m1_we    = tb_we[1];
    assign if_b.m0_we    = tb_we[0];
    assign if_b.m1_we    = tb_we[1];
    assign if_a.m0_addr  = tb_addr[0];
    assign if_a.m1_addr  = tb_addr[1];
    assign if_b.m0_addr  = tb_addr[0];
    assign if_b.m1_addr  = tb_addr[1];
    assign if_a.m0_wdata = tb_wd[0];
    assign if_a.m1_wdata = tb_wd[1];
    assign if_b.m0_wdata = tb_wd[0];
    assign if_b.m1_wdata = tb_wd[1];

    // Peripheral: returns a fixed function of the address, registered one cycle after sys_r
    function automatic logic [31:0] periph_data(input logic [31:0] a);
        if (a == 32'h11) return 32'h0000_FFFF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            if_a.sys_r_line <= '0;
            if_b.sys_r_line <= '0;
        end else begin
            if (if_a.sys_r) if_a.sys_r_line <= periph_data(if_a.sys_r_addr);
            if (if_b.sys_r) if_b.sys_r_line <= periph_data(if_b.sys_r_addr);
        end
    end

    // Reference model state
    int          m_last;
    logic [31:0] e_w_addr, e_r_addr, e_w_line;
    logic [31:0] e_rdata[2];

    int n_chk;
    int n_pass;

    logic        o_w, o_r, o_busy, o_ack0, o_ack1;
    logic [31:0] o_waddr, o_raddr, o_wline, o_rd0, o_rd1;

    task automatic sample();
        if (sel == 0) begin
            o_w = if_a.sys_w; o_r = if_a.sys_r; o_busy = if_a.busy;
            o_ack0 = if_a.m0_ack; o_ack1 = if_a.m1_ack;
            o_waddr = if_a.sys_w_addr; o_raddr = if_a.sys_r_addr; o_wline = if_a.sys_w_line;
            o_rd0 = if_a.m0_rdata; o_rd1 = if_a.m1_rdata;
        end else begin
            o_w = if_b.sys_w; o_r = if_b.sys_r; o_busy = if_b.busy;
            o_ack0 = if_b.m0_ack; o_ack1 = if_b.m1_ack;
            o_waddr = if_b.sys_w_addr; o_raddr = if_b.sys_r_addr; o_wline = if_b.sys_w_line;
            o_rd0 = if_b.m0_rdata; o_rd1 = if_b.m1_rdata;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s (lat=%0d t=%0t): observed %h expected %h",
                    tag, (sel == 1) ? 3 : 1, $time, obs, exp);
    endtask

    task automatic check_all(input bit ew, input bit er, input bit eb, input bit ea0, input bit ea1);
        sample();
        chk("sys_w",      32'(o_w),    32'(ew));
        chk("sys_r",      32'(o_r),    32'(er));
        chk("busy",       32'(o_busy), 32'(eb));
        chk("m0_ack",     32'(o_ack0), 32'(ea0));
        chk("m1_ack",     32'(o_ack1), 32'(ea1));
        chk("sys_w_addr", o_waddr, e_w_addr);
        chk("sys_r_addr", o_raddr, e_r_addr);
        chk("sys_w_line", o_wline, e_w_line);
        chk("m0_rdata",   o_rd0,   e_rdata[0]);
        chk("m1_rdata",   o_rd1,   e_rdata[1]);
    endtask

    task automatic model_reset();
        m_last     = 1;
        e_w_addr   = '0;
        e_r_addr   = '0;
        e_w_line   = '0;
        e_rdata[0] = '0;
        e_rdata[1] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tb_req[0] = 1'b0;
        tb_req[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Called at the negedge of the IDLE cycle in which master m's request is seen (cycle 0).
    // Write: strobe in cycle 1, ack in cycle 2. Read: strobe cycles 1..lat, ack in cycle lat+2.
    task automatic serve(input int m);
        bit          w;
        logic [31:0] a, d;
        int          lat, n;
        w   = tb_we[m];
        a   = tb_addr[m];
        d   = tb_wd[m];
        lat = (sel == 1) ? 3 : 1;
        n   = w ? 2 : lat + 2;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == 1 && w)  begin e_w_addr = a; e_w_line = d; end
            if (k == 1 && !w) e_r_addr = a;
            if (k == n && !w) e_rdata[m] = periph_data(a);
            check_all(w && k == 1, !w && k <= lat, 1'b1, m == 0 && k == n, m == 1 && k == n);
            // Fields changed mid-transaction must not be re-sampled
            if (k == 1) begin
                tb_addr[m] = $urandom;
                tb_wd[m]   = $urandom;
                tb_we[m]   = ~tb_we[m];
            end
            if (k == n) tb_req[m] = 1'b0;
        end
    endtask

    task automatic run(input bit r0, input bit r1, input bit w0, input bit w1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
        bit p0, p1;
        int m;
        tb_we[0] = w0;  tb_we[1] = w1;
        tb_addr[0] = a0; tb_addr[1] = a1;
        tb_wd[0] = d0;  tb_wd[1] = d1;
        tb_req[0] = r0; tb_req[1] = r1;
        p0 = r0;
        p1 = r1;
        while (p0 || p1) begin
            if (p0 && p1) m = 1 - m_last;
            else          m = p1 ? 1 : 0;
            m_last = m;
            serve(m);
            if (m == 0) p0 = 1'b0;
            else        p1 = 1'b0;
            @(negedge clk);
            check_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic random_block(input int count);
        bit [1:0] r, w;
        int       gap;
        for (int i = 0; i < count; i++) begin
            r   = 2'($urandom_range(1, 3));
            w   = 2'($urandom);
            gap = $urandom_range(0, 2);
            run(r[0], r[1], w[0], w[1], $urandom, $urandom, $urandom, $urandom);
            repeat (gap) begin
                @(negedge clk);
                check_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        sel = 0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tb_req[i] = 1'b0; tb_we[i] = 1'b0; tb_addr[i] = '0; tb_wd[i] = '0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        check_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sel = 1;
        check_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sel = 0;
        rst = 1'b0;
        @(negedge clk);

        // Single write from m0, then single read from m1
        run(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hA5A5_A5A5, 32'h0);
        run(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h11, 32'h0, 32'h0);

        // Tie straight after reset goes to m0, then m1; after a lone m0 grant a tie goes to m1
        do_reset();
        run(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h11, 32'h1234_5678, 32'h0);
        run(1'b1, 1'b0, 1'b0, 1'b0, 32'h104, 32'h0, 32'h0, 32'h0);
        run(1'b1, 1'b1, 1'b0, 1'b1, 32'h108, 32'h10C, 32'h0, 32'hCAFE_F00D);

        // Read, write, read on m0: rdata holds across the write
        run(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 32'h0);
        run(1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 32'h0);
        run(1'b1, 1'b0, 1'b0, 1'b0, 32'h30, 32'h0, 32'h0, 32'h0);

        random_block(40);

        // Three-cycle read latency instance
        sel = 1;
        do_reset();
        run(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h0);
        run(1'b1, 1'b1, 1'b0, 1'b0, 32'h48, 32'h4C, 32'h0, 32'h0);
        random_block(15);

        // Reset in the middle of a read aborts it cleanly
        do_reset();
        tb_we[0] = 1'b0; tb_addr[0] = 32'h44; tb_req[0] = 1'b1;
        m_last = 0;
        @(negedge clk);
        e_r_addr = 32'h44;
        check_all(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tb_req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run(1'b1, 1'b0, 1'b1, 1'b0, 32'h50, 32'h0, 32'h0BAD_F00D, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
